// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and helpers for the segment scan controller
package seg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with committed BCD output
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int COUNT_W    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNT_W-1:0]      bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    done
);

  localparam int ACC_W = 4 * NUM_DIGITS + 4;
  localparam int BIT_W = (clog2(COUNT_W) < 1) ? 1 : clog2(COUNT_W);

  conv_state_t        state;
  logic [COUNT_W-1:0] shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   next_acc;
  logic [BIT_W-1:0]   bitcnt;
  logic               lost;

  always_comb begin
    adj = acc;
    for (int n = 0; n < NUM_DIGITS + 1; n++) begin
      if (acc[4*n +: 4] >= 4'd5) adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
    next_acc = {adj[ACC_W-2:0], shreg[COUNT_W-1]};
  end

  // Any nonzero guard nibble on a prefix means the full value is already out of range,
  // so the overflow flag is sticky across the whole conversion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= '0;
      bitcnt <= '0;
      lost   <= 1'b0;
      bcd    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          shreg  <= bin;
          acc    <= '0;
          bitcnt <= '0;
          lost   <= 1'b0;
          state  <= SHIFT;
        end
        SHIFT: begin
          acc   <= next_acc;
          shreg <= shreg << 1;
          lost  <= lost | adj[ACC_W-1] | (|next_acc[ACC_W-1 -: 4]);
          if (bitcnt == BIT_W'(COUNT_W - 1)) state <= COMMIT;
          else bitcnt <= bitcnt + 1'b1;
        end
        COMMIT: begin
          bcd   <= acc[4*NUM_DIGITS-1:0];
          ovf   <= lost;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - binary count to multiplexed BCD digit scan with blanking and overflow
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int COUNT_W     = 10,
  parameter int SCAN_DIV    = 4,
  parameter int LZ_BLANK    = 1,
  parameter int SEL_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COUNT_W-1:0]    count,
  output logic [3:0]            d,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic                  ovf,
  output logic                  upd
);

  localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam int PRE_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] SEL_XOR = (SEL_ACT_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] disp;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              digit;
  logic [3:0]              d_next;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic                    upper_zero;
  logic                    blank;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .COUNT_W   (COUNT_W)
  ) u_conv (
    .clk  (clk),
    .reset(reset),
    .bin  (count),
    .bcd  (disp),
    .ovf  (ovf),
    .done (upd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A slot is blanked only when it and every more significant digit are zero.
  always_comb begin
    digit      = disp[4*idx +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    blank      = (LZ_BLANK != 0) && (idx != '0) && upper_zero;
    sel_onehot = NUM_DIGITS'(1) << idx;
    if (ovf) begin
      d_next   = BLANK_CODE;
      sel_next = sel_onehot;
    end else if (blank) begin
      d_next   = BLANK_CODE;
      sel_next = '0;
    end else begin
      d_next   = digit;
      sel_next = sel_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d       <= 4'd0;
      seg_sel <= NUM_DIGITS'(1) ^ SEL_XOR;
    end else begin
      d       <= d_next;
      seg_sel <= sel_next ^ SEL_XOR;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench over four parameterisations of seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int W = 10;
  localparam int P = W + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] count;
  logic [3:0]   d0, d1, d2, d3;
  logic [5:0]   s0, s3;
  logic [1:0]   s1;
  logic [2:0]   s2;
  logic         ovf0, ovf1, ovf2, ovf3;
  logic         upd0, upd1, upd2, upd3;

  seg_scan_ctrl u0 (
    .clk(clk), .reset(reset), .count(count), .d(d0), .seg_sel(s0), .ovf(ovf0), .upd(upd0)
  );
  seg_scan_ctrl #(.NUM_DIGITS(2)) u1 (
    .clk(clk), .reset(reset), .count(count), .d(d1), .seg_sel(s1), .ovf(ovf1), .upd(upd1)
  );
  seg_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(2)) u2 (
    .clk(clk), .reset(reset), .count(count), .d(d2), .seg_sel(s2), .ovf(ovf2), .upd(upd2)
  );
  seg_scan_ctrl #(.SCAN_DIV(1), .LZ_BLANK(0), .SEL_ACT_LOW(1)) u3 (
    .clk(clk), .reset(reset), .count(count), .d(d3), .seg_sel(s3), .ovf(ovf3), .upd(upd3)
  );

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int unsigned disp = 0;
  int unsigned pend[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s at k=%0d value=%0d: got 0x%0h expected 0x%0h", name, k, disp, actual, expected);
    end
  endtask

  function automatic int unsigned pow10(input int e);
    int unsigned r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Expected bus after edge kk: the slot scheduled for edge kk-1, showing value v.
  function automatic void model(input int nd, input int sd, input int lz, input int al,
                                input int unsigned v, input int kk, output int ed, output int es);
    int idx;
    int sel;
    idx = (kk == 0) ? 0 : ((kk - 1) / sd) % nd;
    if (v >= pow10(nd)) begin
      ed  = 15;
      sel = 1 << idx;
    end else if (lz != 0 && idx > 0 && v < pow10(idx)) begin
      ed  = 15;
      sel = 0;
    end else begin
      ed  = int'((v / pow10(idx)) % 10);
      sel = 1 << idx;
    end
    if (al != 0) sel = (~sel) & ((1 << nd) - 1);
    es = sel;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      k    = 0;
      disp = 0;
      pend.delete();
    end else begin
      k = k + 1;
      if (k % P == 1) pend.push_back(int'(count));
    end
  end

  always @(negedge clk) begin : monitor
    int ed, es;
    int exp_upd;
    exp_upd = (k > 0 && k % P == 0) ? 1 : 0;
    model(6, 4, 1, 0, disp, k, ed, es); check("u0_d", d0, ed); check("u0_sel", s0, es);
    model(2, 4, 1, 0, disp, k, ed, es); check("u1_d", d1, ed); check("u1_sel", s1, es);
    model(3, 2, 1, 0, disp, k, ed, es); check("u2_d", d2, ed); check("u2_sel", s2, es);
    model(6, 1, 0, 1, disp, k, ed, es); check("u3_d", d3, ed); check("u3_sel", s3, es);
    check("u0_upd", upd0, exp_upd);
    check("u1_upd", upd1, exp_upd);
    check("u2_upd", upd2, exp_upd);
    check("u3_upd", upd3, exp_upd);
    if (upd0) begin
      checks++;
      if (pend.size() == 0) begin
        failures++;
        $display("FAIL u0_pop at k=%0d: got upd=1 expected no pending sample", k);
      end else begin
        disp = pend.pop_front();
      end
    end
    check("u0_ovf", ovf0, (disp >= pow10(6)) ? 1 : 0);
    check("u1_ovf", ovf1, (disp >= pow10(2)) ? 1 : 0);
    check("u2_ovf", ovf2, (disp >= pow10(3)) ? 1 : 0);
    check("u3_ovf", ovf3, (disp >= pow10(6)) ? 1 : 0);
  end

  task automatic hold(input int unsigned v, input int n);
    count = W'(v);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int unsigned v;
    bit reached;
    reset = 1'b0;
    count = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;

    hold(987, 60);
    hold(0, 40);
    hold(100, 40);
    hold(99, 40);

    count = W'(1023);
    reset = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (k == 6) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL mid_shift_wait: got k=%0d expected k=6 within 40 cycles", k);
    end
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    hold(1023, 40);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 99);
        2:       v = $urandom_range(0, 999);
        default: v = $urandom_range(0, 1023);
      endcase
      hold(v, $urandom_range(1, 30));
    end
    hold(v, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
